// File: rtl/ring_rng_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// rng_pkg
//   Shared definitions for the ring-oscillator RNG conditioner: the
//   conditioner FSM state encoding and the default health/warm-up constants.
// ---------------------------------------------------------------------------
package rng_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_FAIL   = 2'd3
    } state_t;

    localparam int unsigned RCT_LIMIT_DEFAULT = 32;
    localparam int unsigned WARMUP_DEFAULT    = 64;
    localparam int unsigned RCT_W             = 8;   // saturating repetition counter width
    localparam int unsigned WARM_W            = 10;  // enough for WARMUP up to 1023

endpackage

// File: rtl/ring_rng_conditioner_sync2.sv
// ---------------------------------------------------------------------------
// rng_sync2
//   Two-flop synchroniser for one asynchronous ring-oscillator tap.
//   Ports:
//     clk   - system clock
//     reset - asynchronous active-high reset, clears both flops
//     d     - asynchronous input bit
//     q     - synchronised output, two cycles after d is sampled
// ---------------------------------------------------------------------------
module rng_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state uses non-blocking assignments so both flops
    // sample their inputs from the same clock edge and form a real 2-stage chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ring_rng_conditioner.sv
// ---------------------------------------------------------------------------
// ring_rng_conditioner
//   Synchronises NCH ring-oscillator taps, XOR-mixes them into one bit per
//   cycle, optionally von Neumann debiases the stream, assembles WORD_W-bit
//   words and hands them out over a valid/ready interface.  A repetition-count
//   health test latches a sticky failure and parks the FSM in FAIL.
//   Ports:
//     clk         - system clock
//     reset       - asynchronous active-high reset
//     enable      - run the conditioner; low returns to IDLE (except from FAIL)
//     raw_in      - NCH asynchronous oscillator taps
//     rng_data    - conditioned output word
//     rng_valid   - rng_data holds an unconsumed word
//     rng_ready   - consumer accepts the word this cycle
//     health_fail - sticky repetition-count failure flag
//     fail_clr    - pulse that clears health_fail and leaves FAIL
// ---------------------------------------------------------------------------
module ring_rng_conditioner
    import rng_pkg::*;
#(
    parameter int unsigned NCH       = 4,
    parameter int unsigned WORD_W    = 16,
    parameter int unsigned DEBIAS    = 1,
    parameter int unsigned RCT_LIMIT = RCT_LIMIT_DEFAULT,
    parameter int unsigned WARMUP    = WARMUP_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NCH-1:0]    raw_in,
    output logic [WORD_W-1:0] rng_data,
    output logic              rng_valid,
    input  logic              rng_ready,
    output logic              health_fail,
    input  logic              fail_clr
);

    localparam int unsigned       CNT_W     = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WORD_W - 1);
    localparam logic [WARM_W-1:0] WARM_LAST = (WARMUP > 0) ? WARM_W'(WARMUP - 1) : '0;
    localparam logic [RCT_W-1:0]  RCT_MAX   = RCT_W'(RCT_LIMIT);

    state_t              state;
    logic [NCH-1:0]      sync_bits;
    logic                m;
    logic [WORD_W-1:0]   asm_reg;
    logic [CNT_W-1:0]    bit_cnt;
    logic [RCT_W-1:0]    rct_cnt;
    logic [WARM_W-1:0]   warm_cnt;
    logic                prev_m;
    logic                pair_phase;   // 0: next m is the first of a pair
    logic                pair_first;
    logic                emit;
    logic                emit_bit;
    logic [WORD_W-1:0]   asm_next;
    logic                can_load;
    logic                rct_trip;

    for (genvar i = 0; i < NCH; i++) begin : g_sync
        rng_sync2 u_sync (
            .clk   (clk),
            .reset (reset),
            .d     (raw_in[i]),
            .q     (sync_bits[i])
        );
    end

    assign m        = ^sync_bits;
    assign asm_next = {asm_reg[WORD_W-2:0], emit_bit};
    // The output register is free if empty or being drained this very cycle.
    assign can_load = !rng_valid || rng_ready;
    assign rct_trip = (rct_cnt >= RCT_MAX);

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        emit     = 1'b0;
        emit_bit = 1'b0;
        if (state == ST_RUN) begin
            if (DEBIAS != 0) begin
                // Second bit of a pair: 10 emits 1, 01 emits 0, i.e. the first bit.
                if (pair_phase && (pair_first != m)) begin
                    emit     = 1'b1;
                    emit_bit = pair_first;
                end
            end else begin
                emit     = 1'b1;
                emit_bit = m;
            end
        end
    end

    // NOTE: the assembly register is ordinary datapath state, so it is reset
    // along with everything else rather than left undefined.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            rng_data    <= '0;
            rng_valid   <= 1'b0;
            health_fail <= 1'b0;
            asm_reg     <= '0;
            bit_cnt     <= '0;
            rct_cnt     <= '0;
            warm_cnt    <= '0;
            prev_m      <= 1'b0;
            pair_phase  <= 1'b0;
            pair_first  <= 1'b0;
        end else begin
            // A completed transfer empties the output; a load below overrides.
            if (rng_valid && rng_ready) begin
                rng_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        warm_cnt   <= '0;
                        pair_phase <= 1'b0;
                        state      <= (WARMUP == 0) ? ST_RUN : ST_WARMUP;
                    end
                end

                ST_WARMUP, ST_RUN: begin
                    if (!enable) begin
                        state     <= ST_IDLE;
                        asm_reg   <= '0;
                        bit_cnt   <= '0;
                        rng_valid <= 1'b0;
                        rct_cnt   <= '0;
                    end else if (rct_trip) begin
                        state       <= ST_FAIL;
                        health_fail <= 1'b1;
                        rng_valid   <= 1'b0;
                        asm_reg     <= '0;
                        bit_cnt     <= '0;
                        rct_cnt     <= '0;
                    end else begin
                        // Repetition count: a zero count means no previous bit yet.
                        prev_m <= m;
                        if ((rct_cnt == '0) || (m != prev_m)) begin
                            rct_cnt <= RCT_W'(1);
                        end else if (rct_cnt != '1) begin
                            rct_cnt <= rct_cnt + RCT_W'(1);
                        end

                        if (state == ST_WARMUP) begin
                            warm_cnt <= warm_cnt + WARM_W'(1);
                            if (warm_cnt == WARM_LAST) begin
                                state      <= ST_RUN;
                                pair_phase <= 1'b0;
                            end
                        end else begin
                            pair_phase <= !pair_phase;
                            if (!pair_phase) begin
                                pair_first <= m;
                            end

                            if (bit_cnt == CNT_FULL) begin
                                // A parked full word leaves as soon as the output frees;
                                // a bit emitted in that same cycle starts the next word.
                                if (can_load) begin
                                    rng_data  <= asm_reg;
                                    rng_valid <= 1'b1;
                                    if (emit) begin
                                        asm_reg <= asm_next;
                                        bit_cnt <= CNT_W'(1);
                                    end else begin
                                        bit_cnt <= '0;
                                    end
                                end
                            end else if (emit) begin
                                if (bit_cnt == CNT_LAST) begin
                                    if (can_load) begin
                                        rng_data  <= asm_next;
                                        rng_valid <= 1'b1;
                                        bit_cnt   <= '0;
                                    end else begin
                                        asm_reg <= asm_next;
                                        bit_cnt <= CNT_FULL;
                                    end
                                end else begin
                                    asm_reg <= asm_next;
                                    bit_cnt <= bit_cnt + CNT_W'(1);
                                end
                            end
                        end
                    end
                end

                ST_FAIL: begin
                    rng_valid <= 1'b0;
                    if (fail_clr) begin
                        health_fail <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
